// File: rtl/izh_pkg.sv
// Shared types, constants and sign-magnitude arithmetic helpers for the Izhikevich step engine.
// Format: MSB sign, remaining bits magnitude with Q fractional bits.
package izh_pkg;

  localparam int N = 20;
  localparam int Q = 8;

  localparam logic [N-1:0] K004     = 20'h0000A;
  localparam logic [N-1:0] K5       = 20'h00500;
  localparam logic [N-1:0] K140     = 20'h08C00;
  localparam logic [N-1:0] V_TH_DEF = 20'h01E00;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    MUL_VV  = 4'd1,
    MUL_K04 = 4'd2,
    MUL_5V  = 4'd3,
    MUL_DV  = 4'd4,
    MUL_BV  = 4'd5,
    MUL_A   = 4'd6,
    MUL_DW  = 4'd7,
    UPD     = 4'd8,
    OUT     = 4'd9
  } izh_state_t;

  function automatic logic [N-1:0] sm_neg(input logic [N-1:0] a);
    return {~a[N-1], a[N-2:0]};
  endfunction

  // Truncating multiply; magnitude bits above the format wrap away.
  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-3:0] full;
    full = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
    return {a[N-1] ^ b[N-1], full[Q+N-2:Q]};
  endfunction

  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-2:0] ma;
    logic [N-2:0] mb;
    logic [N-2:0] mag;
    logic         sgn;
    ma = a[N-2:0];
    mb = b[N-2:0];
    if (a[N-1] == b[N-1]) begin
      mag = ma + mb;
      sgn = a[N-1];
    end else if (ma >= mb) begin
      mag = ma - mb;
      sgn = a[N-1];
    end else begin
      mag = mb - ma;
      sgn = b[N-1];
    end
    // A zero result is always reported as +0.
    sgn = sgn & (|mag);
    return {sgn, mag};
  endfunction

  // Signed a >= b where +0 and -0 compare equal.
  function automatic logic sm_ge(input logic [N-1:0] a, input logic [N-1:0] b);
    logic a_neg;
    logic b_neg;
    a_neg = a[N-1] & (|a[N-2:0]);
    b_neg = b[N-1] & (|b[N-2:0]);
    if (a_neg != b_neg) begin
      return ~a_neg;
    end else if (!a_neg) begin
      return a[N-2:0] >= b[N-2:0];
    end else begin
      return a[N-2:0] <= b[N-2:0];
    end
  endfunction

endpackage

// File: rtl/izh_op_sel.sv
// Operand mux for the single shared multiplier; selects the factor pair for the current FSM state.
module izh_op_sel
  import izh_pkg::*;
(
  input  izh_state_t       i_state,
  input  logic [N-1:0]     i_v,
  input  logic [N-1:0]     i_w,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  input  logic [N-1:0]     i_step,
  input  logic [N-1:0]     i_p,
  input  logic [N-1:0]     i_s,
  input  logic [N-1:0]     i_bq,
  output logic [N-1:0]     o_op_a,
  output logic [N-1:0]     o_op_b
);

  // Factor pair per multiply state; idle states feed zeros.
  always_comb begin
    o_op_a = {N{1'b0}};
    o_op_b = {N{1'b0}};
    case (i_state)
      MUL_VV:  begin o_op_a = i_v;    o_op_b = i_v;    end
      MUL_K04: begin o_op_a = K004;   o_op_b = i_p;    end
      MUL_5V:  begin o_op_a = K5;     o_op_b = i_v;    end
      MUL_DV:  begin o_op_a = i_s;    o_op_b = i_step; end
      MUL_BV:  begin o_op_a = i_b;    o_op_b = i_v;    end
      MUL_A:   begin o_op_a = i_a;    o_op_b = sm_add(i_bq, sm_neg(i_w)); end
      MUL_DW:  begin o_op_a = i_bq;   o_op_b = i_step; end
      default: begin o_op_a = {N{1'b0}}; o_op_b = {N{1'b0}}; end
    endcase
  end

endmodule

// File: rtl/izh_step_engine.sv
// Izhikevich neuron per-timestep update engine with one time-shared multiplier.
// Optional spike counter output enabled by defining IZH_SPIKE_CNT_EN.
module izh_step_engine
  import izh_pkg::*;
#(
  parameter logic [N-1:0] V_TH = V_TH_DEF
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] v_in,
  input  logic [N-1:0] w_in,
  input  logic [N-1:0] i_in,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic [N-1:0] c_in,
  input  logic [N-1:0] d_in,
  input  logic [N-1:0] step_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] v_out,
  output logic [N-1:0] w_out,
`ifdef IZH_SPIKE_CNT_EN
  output logic [15:0]  spike_count,
`endif
  output logic         spike
);

  izh_state_t   r_state;
  izh_state_t   w_state_nxt;
  logic [N-1:0] r_v, r_w, r_i, r_a, r_b, r_c, r_d, r_step;
  logic [N-1:0] r_p, r_s, r_dv, r_bq, r_dw;
  logic         r_in_ready, r_out_valid, r_spike;
  logic [N-1:0] r_v_out, r_w_out;
  logic [N-1:0] w_op_a, w_op_b, w_prod, w_s_sum, w_vn, w_wn;
  logic         w_fire, w_accept;

  izh_op_sel u_op_sel (
    .i_state (r_state),
    .i_v     (r_v),
    .i_w     (r_w),
    .i_a     (r_a),
    .i_b     (r_b),
    .i_step  (r_step),
    .i_p     (r_p),
    .i_s     (r_s),
    .i_bq    (r_bq),
    .o_op_a  (w_op_a),
    .o_op_b  (w_op_b)
  );

  // Shared multiplier and the combinational add network around it.
  always_comb begin
    w_prod   = sm_mul(w_op_a, w_op_b);
    w_s_sum  = sm_add(sm_add(sm_add(sm_add(r_p, w_prod), K140), sm_neg(r_w)), r_i);
    w_vn     = sm_add(r_v, r_dv);
    w_wn     = sm_add(r_w, r_dw);
    w_fire   = sm_ge(w_vn, V_TH);
    w_accept = in_valid & r_in_ready;
  end

  // Next-state sequencing: one multiply per state, then update and hold in OUT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = MUL_VV; else w_state_nxt = IDLE;
      MUL_VV:  w_state_nxt = MUL_K04;
      MUL_K04: w_state_nxt = MUL_5V;
      MUL_5V:  w_state_nxt = MUL_DV;
      MUL_DV:  w_state_nxt = MUL_BV;
      MUL_BV:  w_state_nxt = MUL_A;
      MUL_A:   w_state_nxt = MUL_DW;
      MUL_DW:  w_state_nxt = UPD;
      UPD:     w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = IDLE; else w_state_nxt = OUT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, handshake flags, operand capture and intermediate products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_v         <= {N{1'b0}};
      r_w         <= {N{1'b0}};
      r_i         <= {N{1'b0}};
      r_a         <= {N{1'b0}};
      r_b         <= {N{1'b0}};
      r_c         <= {N{1'b0}};
      r_d         <= {N{1'b0}};
      r_step      <= {N{1'b0}};
      r_p         <= {N{1'b0}};
      r_s         <= {N{1'b0}};
      r_dv        <= {N{1'b0}};
      r_bq        <= {N{1'b0}};
      r_dw        <= {N{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == OUT);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_v    <= v_in;
            r_w    <= w_in;
            r_i    <= i_in;
            r_a    <= a_in;
            r_b    <= b_in;
            r_c    <= c_in;
            r_d    <= d_in;
            r_step <= step_in;
          end
        end
        MUL_VV:  r_p  <= w_prod;
        MUL_K04: r_p  <= w_prod;
        MUL_5V:  r_s  <= w_s_sum;
        MUL_DV:  r_dv <= w_prod;
        MUL_BV:  r_bq <= w_prod;
        MUL_A:   r_bq <= w_prod;
        MUL_DW:  r_dw <= w_prod;
        default: ;
      endcase
    end
  end

  // Result registers: spike resets v to c and bumps w by d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v_out <= {N{1'b0}};
      r_w_out <= {N{1'b0}};
      r_spike <= 1'b0;
    end else if (r_state == UPD) begin
      r_v_out <= w_fire ? r_c : w_vn;
      r_w_out <= w_fire ? sm_add(w_wn, r_d) : w_wn;
      r_spike <= w_fire;
    end
  end

`ifdef IZH_SPIKE_CNT_EN
  logic [15:0] r_spike_count;

  // Saturating count of spiking updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spike_count <= 16'h0000;
    end else if ((r_state == UPD) && w_fire && (r_spike_count != 16'hFFFF)) begin
      r_spike_count <= r_spike_count + 16'h0001;
    end
  end

  assign spike_count = r_spike_count;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign v_out     = r_v_out;
  assign w_out     = r_w_out;
  assign spike     = r_spike;

endmodule

// File: tb/tb_izh_step_engine.sv
// Scoreboard bench for izh_step_engine: directed bundles with hand-computed results and latency checks.
module tb_izh_step_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] v_in, w_in, i_in, a_in, b_in, c_in, d_in, step_in;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] v_out, w_out;
  logic        spike;
`ifdef IZH_SPIKE_CNT_EN
  logic [15:0] spike_count;
`endif

  typedef struct {
    logic [19:0] v;
    logic [19:0] w;
    logic        s;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   lat_seen = 1'b0;

  localparam logic [19:0] A02  = 20'h00005;
  localparam logic [19:0] B02  = 20'h00033;
  localparam logic [19:0] CM65 = 20'h84100;
  localparam logic [19:0] D8   = 20'h00800;
  localparam logic [19:0] ST1  = 20'h00100;

  izh_step_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .v_in      (v_in),
    .w_in      (w_in),
    .i_in      (i_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .d_in      (d_in),
    .step_in   (step_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .v_out     (v_out),
    .w_out     (w_out),
`ifdef IZH_SPIKE_CNT_EN
    .spike_count (spike_count),
`endif
    .spike     (spike)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency on first sight of out_valid, values on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      lat_seen = 1'b0;
    end else if (out_valid) begin
      if (!lat_seen) begin
        lat_seen = 1'b1;
        if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
        else chk("latency", cyc - sb[0].acc, 32'd8);
      end
      if (out_ready) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("v_out", {12'd0, v_out}, {12'd0, e.v});
          chk("w_out", {12'd0, w_out}, {12'd0, e.w});
          chk("spike", {31'd0, spike}, {31'd0, e.s});
        end
        lat_seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [19:0] v, w, i, a, b, c, d, st,
                       input logic [19:0] ev, ew, input logic es, input bit push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_wait", 32'd0, 32'd1);
      return;
    end
    v_in = v; w_in = w; i_in = i; a_in = a; b_in = b; c_in = c; d_in = d; step_in = st;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (push) begin
      e.v = ev; e.w = ew; e.s = es; e.acc = cyc;
      sb.push_back(e);
    end
    in_valid = 1'b0;
    v_in = ~v; w_in = ~w; i_in = ~i; a_in = ~a; b_in = ~b; c_in = ~c; d_in = ~d; step_in = ~st;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    int bad;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    v_in = '0; w_in = '0; i_in = '0; a_in = '0; b_in = '0; c_in = '0; d_in = '0; step_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_v_out",     {12'd0, v_out},     32'd0);
    chk("rst_w_out",     {12'd0, w_out},     32'd0);
    chk("rst_spike",     {31'd0, spike},     32'd0);
`ifdef IZH_SPIKE_CNT_EN
    chk("rst_spike_count", {16'd0, spike_count}, 32'd0);
`endif
    @(negedge clk) rst = 1'b0;

    // v=0, i=0, step=1: dv=140 -> spike
    issue(20'h00000, 20'h00000, 20'h00000, A02, B02, CM65, D8, ST1, CM65, D8, 1'b1, 1'b1);
    // i=-140 cancels the constant term
    issue(20'h00000, 20'h00000, 20'h88C00, A02, B02, CM65, D8, ST1, 20'h00000, 20'h00000, 1'b0, 1'b1);
    // v exactly at threshold with step=0
    issue(20'h01E00, 20'h00000, 20'h00000, A02, B02, CM65, D8, 20'h00000, CM65, D8, 1'b1, 1'b1);
    // negative state, step=0: unchanged
    issue(20'h84600, 20'h80E00, 20'h00000, A02, B02, CM65, D8, 20'h00000, 20'h84600, 20'h80E00, 1'b0, 1'b1);
    // v=-65, w=-10, i=10, step=0.5: every product non-trivial, v*v wraps
    issue(20'h84100, 20'h80A00, 20'h00A00, A02, B02, CM65, D8, 20'h00080, 20'h890FB, 20'h80A07, 1'b0, 1'b1);
    drain();

    // Backpressure
    @(posedge clk); #1 out_ready = 1'b0;
    issue(20'h00000, 20'h00000, 20'h00000, A02, B02, CM65, D8, ST1, CM65, D8, 1'b1, 1'b1);
    seen = 0;
    while (!out_valid && seen < 20) begin
      @(negedge clk);
      seen++;
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || v_out !== CM65 || w_out !== D8 || spike !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    chk("bp_hold_stable", bad, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_out_valid_fall", {31'd0, out_valid}, 32'd0);
    chk("bp_in_ready_back",  {31'd0, in_ready},  32'd1);
    drain();
`ifdef IZH_SPIKE_CNT_EN
    chk("spike_count_3", {16'd0, spike_count}, 32'd3);
`endif

    // Reset while in MUL_DV
    issue(20'h84100, 20'h80A00, 20'h00A00, A02, B02, CM65, D8, 20'h00080, 20'h0, 20'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_v_out",     {12'd0, v_out},     32'd0);
    chk("abort_w_out",     {12'd0, w_out},     32'd0);
    chk("abort_spike",     {31'd0, spike},     32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd0);
`ifdef IZH_SPIKE_CNT_EN
    chk("abort_spike_count", {16'd0, spike_count}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 32'd0);

    issue(20'h00000, 20'h00000, 20'h00000, A02, B02, CM65, D8, ST1, CM65, D8, 1'b1, 1'b1);
    issue(20'h01E00, 20'h00000, 20'h00000, A02, B02, CM65, D8, 20'h00000, CM65, D8, 1'b1, 1'b1);
    issue(20'h84100, 20'h80A00, 20'h00A00, A02, B02, CM65, D8, 20'h00080, 20'h890FB, 20'h80A07, 1'b0, 1'b1);
    issue(20'h00000, 20'h00000, 20'h00000, A02, B02, CM65, D8, ST1, CM65, D8, 1'b1, 1'b1);
    drain();
`ifdef IZH_SPIKE_CNT_EN
    chk("spike_count_after_rst", {16'd0, spike_count}, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/izh_step_engine.md
Name: izh_step_engine

Overview:
- Sequential state-update engine for one Izhikevich neuron. It sits downstream of the combinational dv expression and is its consumer.
- Accepts a state/parameter bundle over a valid/ready handshake and computes dv and dw with a single time-shared fixed-point multiplier.
- Integrates v and w, applies spike detection and reset (v←c, w←w+d), and returns the new state over a second valid/ready handshake.
- Used as the per-timestep update core in the 20-bit neuron datapath.

Parameters:
- N, 20, total word width.
- Q, 8, fractional bits.
- V_TH, 20'h01E00 (30.0), spike threshold in the same fixed-point format.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request bundle valid.
- in_ready  output  1  engine can accept a bundle.
- v_in  input  N  membrane potential.
- w_in  input  N  recovery variable.
- i_in  input  N  input current.
- a_in, b_in, c_in, d_in  input  N each  Izhikevich parameters.
- step_in  input  N  integration timestep.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- v_out  output  N  updated v.
- w_out  output  N  updated w.
- spike  output  1  spike occurred this update.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Number format: the codebase's mult/add/negator format, sign-magnitude, MSB = sign, Q fractional bits. All arithmetic goes through those semantics: truncating multiply, no saturation, wrap on overflow.
- Constants: K004 = 20'h0000A, K5 = 20'h00500, K140 = 20'h08C00.
- Reset values: in_ready=0 while rst is high, then 1 in IDLE. out_valid=0, v_out=0, w_out=0, spike=0. The FSM goes to IDLE and all operand registers are cleared.
- Accept: a bundle is taken on the rising edge where in_valid&&in_ready. All inputs are latched there; later input changes are ignored. in_ready=1 only in IDLE.
- FSM and multiplies (one per state, one cycle each, product registered):
  - MUL_VV: p=v*v
  - MUL_K04: t=K004*p
  - MUL_5V: u=5*v; s=t+u+K140+(-w)+i, combinational adds, registered
  - MUL_DV: dv=s*step
  - MUL_BV: bv=b*v
  - MUL_A: q=a*(bv+(-w))
  - MUL_DW: dw=q*step
  - UPD: vn=v+dv, wn=w+dw
  - OUT
- UPD outcome:
  - If vn >= V_TH (signed compare, sign-magnitude aware, +0 == −0), then v_out=c, w_out=wn+d, spike=1.
  - Otherwise v_out=vn, w_out=wn, spike=0.
- Latency: out_valid rises exactly 8 cycles after the accept edge.
- OUT state:
  - out_valid, v_out, w_out and spike are held stable until out_ready is sampled high.
  - The FSM then returns to IDLE and out_valid drops the next cycle. v_out, w_out and spike keep their last values.
- Throughput: one result per 10 cycles minimum. There is no accept during OUT, even if out_ready is high.
- step=0: dv=dw=0, and the spike check still applies to the unchanged v.
- rst asserted mid-operation: immediate abort and return to reset values. No partial result is emitted.

Optional Feature:
- Macro: IZH_SPIKE_CNT_EN.
- Defined: adds output spike_count [15:0].
  - Increments on each UPD with spike=1 and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package izh_pkg holds:
  - localparams K004, K5, K140, default V_TH;
  - typedef enum izh_state_t {IDLE, MUL_VV, MUL_K04, MUL_5V, MUL_DV, MUL_BV, MUL_A, MUL_DW, UPD, OUT};
  - helper function sm_ge for the sign-magnitude compare.
- Sub-module izh_op_sel: combinational multiplier-operand mux keyed by state, feeding one mult instance.
- Top level holds the FSM, registers and the spike/reset logic.

Test Plan:
- v=0, w=0, i=0, a=0.02, b=0.2, c=−65, d=8, step=1.0:
  - dv=140, so vn=140 ≥ 30;
  - expect spike=1, v_out=−65 (sign-magnitude 20'h84100), w_out=8.0 (20'h00800);
  - out_valid exactly 8 cycles after accept.
- v=0, w=0, i=−140, step=1.0 → dv=0, v_out=0, w_out=0, spike=0.
- v=30.0, w=0, step=0 → boundary, expect spike=1, v_out=c, w_out=d.
- v=−70, w=−14, step=0 → v_out=−70, w_out=−14, spike=0.
- Backpressure: hold out_ready=0 for 20 cycles.
  - out_valid and the outputs stay stable, and in_ready stays 0.
  - After out_ready=1, out_valid falls the next cycle and in_ready returns to 1.
- Reset mid-operation: assert rst in MUL_DV.
  - Outputs are zero asynchronously, and no out_valid appears.
  - A fresh bundle after reset produces the correct result.
  - With IZH_SPIKE_CNT_EN defined, spike_count resets to 0 and counts 3 after three spiking updates.
